cpu_sequencer: RTL and testbench

Instruction sequencer for the tt_um_cthorens_cpu core. It fetches 8-bit instructions from a registered-read program ROM, decodes them, and drives the register-file/ALU datapath control lines (read selects, ALU op, write enable and source). It also owns the PC, the instruction register and the zero flag. Each instruction takes three cycles (FETCH, DECODE, EXEC) until HALT.

---
 rtl/cpu_pkg.sv | 27 ++
 rtl/cpu_decoder.sv | 30 +++
 rtl/cpu_sequencer.sv | 117 +++++++++++
 tb/tb_cpu_sequencer.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared types and constants for the tt_um_cthorens_cpu sequencer and decoder.
package cpu_pkg;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        DECODE = 2'd1,
        EXEC   = 2'd2,
        HALTED = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        CLS_SYS = 2'b00,
        CLS_LDI = 2'b01,
        CLS_ALU = 2'b10,
        CLS_JMP = 2'b11
    } cls_t;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_XOR = 2'b11
    } alu_op_t;

    localparam logic [7:0] HALT_OPCODE = 8'h3F;

endpackage

// File: rtl/cpu_decoder.sv
// Combinational instruction-register decoder: splits IR into its fields.
module cpu_decoder
    import cpu_pkg::*;
#(
    parameter int PC_W = 5
) (
    input  logic [7:0]      ir,
    output cls_t            cls,
    output logic [1:0]      rd,
    output logic [1:0]      rs,
    output alu_op_t         op,
    output logic [7:0]      imm,
    output logic [PC_W-1:0] target,
    output logic            is_halt,
    output logic            is_cond
);

    // Field extraction; the ALU op is forced to ADD outside the ALU class.
    always_comb begin
        cls     = cls_t'(ir[7:6]);
        rd      = ir[5:4];
        rs      = ir[3:2];
        op      = (cls == CLS_ALU) ? alu_op_t'(ir[1:0]) : ALU_ADD;
        imm     = {4'b0000, ir[3:0]};
        target  = ir[PC_W-1:0];
        is_halt = (ir == HALT_OPCODE);
        is_cond = ir[5];
    end

endmodule

// File: rtl/cpu_sequencer.sv
// Three-cycle FETCH/DECODE/EXEC instruction sequencer owning PC, IR and the
// zero flag, and driving the register-file/ALU control lines from IR.
module cpu_sequencer
    import cpu_pkg::*;
#(
    parameter int PC_W = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            i_en,
    output logic [PC_W-1:0] o_rom_addr,
    input  logic [7:0]      i_rom_data,
    output logic [1:0]      o_rs_a,
    output logic [1:0]      o_rs_b,
    output logic [1:0]      o_alu_op,
    output logic            o_reg_we,
    output logic [1:0]      o_reg_waddr,
    output logic            o_wsel,
    output logic [7:0]      o_imm,
    input  logic            i_alu_zero,
    output logic            o_halted,
    output logic            o_retire
);

    state_t          state, state_nxt;
    logic [PC_W-1:0] pc, pc_nxt;
    logic [7:0]      ir, ir_nxt;
    logic            z, z_nxt;
    logic            reg_we, retire;

    cls_t            cls;
    logic [1:0]      rd, rs;
    alu_op_t         op;
    logic [7:0]      imm;
    logic [PC_W-1:0] target;
    logic            is_halt, is_cond;

    cpu_decoder #(.PC_W(PC_W)) u_decoder (
        .ir      (ir),
        .cls     (cls),
        .rd      (rd),
        .rs      (rs),
        .op      (op),
        .imm     (imm),
        .target  (target),
        .is_halt (is_halt),
        .is_cond (is_cond)
    );

    // Next-state, PC/IR/Z update and write/retire strobes; i_en low holds everything.
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        ir_nxt    = ir;
        z_nxt     = z;
        reg_we    = 1'b0;
        retire    = 1'b0;
        case (state)
            FETCH: begin
                if (i_en) state_nxt = DECODE;
            end
            DECODE: begin
                if (i_en) begin
                    ir_nxt    = i_rom_data;
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                if (i_en) begin
                    retire = 1'b1;
                    reg_we = (cls == CLS_LDI) || (cls == CLS_ALU);
                    if (cls == CLS_ALU) z_nxt = i_alu_zero;
                    if (is_halt) begin
                        state_nxt = HALTED;
                    end else begin
                        state_nxt = FETCH;
                        if ((cls == CLS_JMP) && (!is_cond || z)) pc_nxt = target;
                        else                                     pc_nxt = pc + PC_W'(1);
                    end
                end
            end
            HALTED: begin
                state_nxt = HALTED;
            end
            default: begin
                state_nxt = FETCH;
            end
        endcase
    end

    // State, PC, IR and Z registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= FETCH;
            pc    <= '0;
            ir    <= '0;
            z     <= 1'b0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            ir    <= ir_nxt;
            z     <= z_nxt;
        end
    end

    assign o_rom_addr  = pc;
    assign o_rs_a      = rd;
    assign o_rs_b      = rs;
    assign o_reg_waddr = rd;
    assign o_imm       = imm;
    assign o_alu_op    = op;
    assign o_wsel      = (cls == CLS_LDI);
    assign o_reg_we    = rst_n & reg_we;
    assign o_retire    = rst_n & retire;
    assign o_halted    = (state == HALTED);

endmodule

// File: tb/tb_cpu_sequencer.sv
// Scoreboard bench for cpu_sequencer: directed programs push expected retire
// records; a monitor pops and compares on every o_retire pulse.
module tb_cpu_sequencer;

    localparam int PC_W = 5;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            i_en;
    logic [PC_W-1:0] o_rom_addr;
    logic [7:0]      i_rom_data = 8'h00;
    logic [1:0]      o_rs_a, o_rs_b, o_alu_op, o_reg_waddr;
    logic            o_reg_we, o_wsel, o_halted, o_retire;
    logic [7:0]      o_imm;
    logic            i_alu_zero;

    logic [7:0] rom [32];
    int cyc = 0;
    int n_total = 0;
    int n_pass = 0;

    typedef struct {
        int          c;
        logic [22:0] f;
    } exp_t;
    exp_t exp_q[$];

    cpu_sequencer #(.PC_W(PC_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_en        (i_en),
        .o_rom_addr  (o_rom_addr),
        .i_rom_data  (i_rom_data),
        .o_rs_a      (o_rs_a),
        .o_rs_b      (o_rs_b),
        .o_alu_op    (o_alu_op),
        .o_reg_we    (o_reg_we),
        .o_reg_waddr (o_reg_waddr),
        .o_wsel      (o_wsel),
        .o_imm       (o_imm),
        .i_alu_zero  (i_alu_zero),
        .o_halted    (o_halted),
        .o_retire    (o_retire)
    );

    always #5 clk = ~clk;

    // Registered-read program ROM.
    always @(posedge clk) i_rom_data <= rom[o_rom_addr];

    // Cycle index: 0 is the first cycle with rst_n high.
    always @(posedge clk) cyc <= rst_n ? cyc + 1 : 0;

    task automatic chk(input string name, input int act, input int expv);
        n_total++;
        if (act == expv) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    endtask

    task automatic push(input int c, input logic [4:0] pc, input logic we,
                        input logic [1:0] wa, input logic ws, input logic [7:0] imm,
                        input logic [1:0] ra, input logic [1:0] rb, input logic [1:0] op);
        exp_t e;
        e.c = c;
        e.f = {we, ws, wa, ra, rb, op, imm, pc};
        exp_q.push_back(e);
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 32; i++) rom[i] = 8'h00;
    endtask

    task automatic release_reset();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Move to 1 time unit after the edge that starts cycle c.
    task automatic enter(input int c);
        for (int k = 0; k < 200; k++) begin
            @(posedge clk);
            #1;
            if (cyc == c) return;
        end
        chk("enter_timeout", cyc, c);
    endtask

    // Move to the falling edge inside cycle c.
    task automatic at_neg(input int c);
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (cyc == c) return;
        end
        chk("at_neg_timeout", cyc, c);
    endtask

    // Monitor: every retire pulse must match the oldest expected record.
    always @(negedge clk) begin
        if (o_retire) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL spurious_retire: got retire at cycle %0d addr %0h expected none", cyc, o_rom_addr);
            end else begin
                exp_t e;
                logic [22:0] act;
                e = exp_q.pop_front();
                act = {o_reg_we, o_wsel, o_reg_waddr, o_rs_a, o_rs_b, o_alu_op, o_imm, o_rom_addr};
                chk("retire_cycle", cyc, e.c);
                chk("retire_fields", int'(act), int'(e.f));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        i_en = 1'b1;
        i_alu_zero = 1'b0;
        clear_rom();

        // Reset state and a single NOP
        @(negedge clk);
        @(negedge clk);
        chk("rst_we", o_reg_we, 0);
        chk("rst_retire", o_retire, 0);
        chk("rst_halted", o_halted, 0);
        push(2, 5'd0, 1'b0, 2'd0, 1'b0, 8'h00, 2'd0, 2'd0, 2'd0);
        release_reset();
        at_neg(0);
        chk("c0_addr", o_rom_addr, 0);
        chk("c0_we", o_reg_we, 0);
        chk("c0_halted", o_halted, 0);
        enter(3);
        rst_n = 1'b0;

        // LDI, LDI, ALU SUB, HALT
        clear_rom();
        rom[0] = 8'h55; rom[1] = 8'h62; rom[2] = 8'h91; rom[3] = 8'h3F;
        push(2,  5'd0, 1'b1, 2'd1, 1'b1, 8'h05, 2'd1, 2'd1, 2'd0);
        push(5,  5'd1, 1'b1, 2'd2, 1'b1, 8'h02, 2'd2, 2'd0, 2'd0);
        push(8,  5'd2, 1'b1, 2'd1, 1'b0, 8'h01, 2'd1, 2'd0, 2'd1);
        push(11, 5'd3, 1'b0, 2'd3, 1'b0, 8'h0F, 2'd3, 2'd3, 2'd0);
        release_reset();
        at_neg(11);
        chk("halt_pre", o_halted, 0);
        at_neg(12);
        chk("halt_rise", o_halted, 1);
        at_neg(20);
        chk("halt_stay", o_halted, 1);
        chk("halt_pc", o_rom_addr, 3);
        chk("halt_we", o_reg_we, 0);
        enter(21);
        rst_n = 1'b0;

        // JZ taken after a SUB that produced zero
        clear_rom();
        rom[0] = 8'h91; rom[1] = 8'hE7;
        i_alu_zero = 1'b1;
        push(2, 5'd0, 1'b1, 2'd1, 1'b0, 8'h01, 2'd1, 2'd0, 2'd1);
        push(5, 5'd1, 1'b0, 2'd2, 1'b0, 8'h07, 2'd2, 2'd1, 2'd0);
        release_reset();
        at_neg(0);
        chk("halt_cleared", o_halted, 0);
        at_neg(6);
        chk("jz_taken_addr", o_rom_addr, 7);
        enter(7);
        rst_n = 1'b0;

        // JZ not taken after a nonzero SUB
        i_alu_zero = 1'b0;
        push(2, 5'd0, 1'b1, 2'd1, 1'b0, 8'h01, 2'd1, 2'd0, 2'd1);
        push(5, 5'd1, 1'b0, 2'd2, 1'b0, 8'h07, 2'd2, 2'd1, 2'd0);
        release_reset();
        at_neg(6);
        chk("jz_fall_addr", o_rom_addr, 2);
        enter(7);
        rst_n = 1'b0;

        // JMP 31, then PC wraps to 0 after the NOP at 31
        clear_rom();
        rom[0] = 8'hDF;
        push(2, 5'd0,  1'b0, 2'd1, 1'b0, 8'h0F, 2'd1, 2'd3, 2'd0);
        push(5, 5'd31, 1'b0, 2'd0, 1'b0, 8'h00, 2'd0, 2'd0, 2'd0);
        release_reset();
        at_neg(3);
        chk("jmp31_addr", o_rom_addr, 31);
        at_neg(6);
        chk("wrap_addr", o_rom_addr, 0);
        enter(7);
        rst_n = 1'b0;

        // JMP 3
        clear_rom();
        rom[0] = 8'hC3;
        push(2, 5'd0, 1'b0, 2'd0, 1'b0, 8'h03, 2'd0, 2'd0, 2'd0);
        release_reset();
        at_neg(3);
        chk("jmp3_addr", o_rom_addr, 3);
        enter(4);
        rst_n = 1'b0;

        // i_en low for four cycles in DECODE delays LDI retire to cycle 6
        clear_rom();
        rom[0] = 8'h55;
        push(6, 5'd0, 1'b1, 2'd1, 1'b1, 8'h05, 2'd1, 2'd1, 2'd0);
        release_reset();
        enter(1);
        i_en = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            at_neg(k);
            chk("hold_addr", o_rom_addr, 0);
            chk("hold_we", o_reg_we, 0);
            chk("hold_retire", o_retire, 0);
            chk("hold_ir", o_rs_a, 0);
        end
        enter(5);
        i_en = 1'b1;
        enter(7);
        rst_n = 1'b0;

        // Reset during EXEC of LDI, with Z previously set
        clear_rom();
        rom[0] = 8'h91; rom[1] = 8'h55;
        i_alu_zero = 1'b1;
        push(2, 5'd0, 1'b1, 2'd1, 1'b0, 8'h01, 2'd1, 2'd0, 2'd1);
        release_reset();
        enter(5);
        rst_n = 1'b0;
        at_neg(5);
        chk("rstexec_we", o_reg_we, 0);
        chk("rstexec_retire", o_retire, 0);
        clear_rom();
        rom[0] = 8'hE7;
        i_alu_zero = 1'b0;
        push(2, 5'd0, 1'b0, 2'd2, 1'b0, 8'h07, 2'd2, 2'd1, 2'd0);
        release_reset();
        at_neg(0);
        chk("rstexec_pc", o_rom_addr, 0);
        at_neg(3);
        chk("rstexec_z_cleared", o_rom_addr, 1);

        chk("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
